// File: rtl/pipe_stage_skid_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_pkg : shared pipeline constants (occupancy encoding, NOP)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Canonical instruction-stage bubble (addi x0, x0, 0).
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  function automatic logic occ_accepts(input occ_e s);
    return (s != OCC_FULL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage_entry.sv
// ---------------------------------------------------------------------------
// pipe_stage_entry : WIDTH-bit register, load enable, sync clear to BUBBLE
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_stage_entry #(
  parameter int unsigned       WIDTH  = 64,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!reset_n || clear_i) begin
      data_q <= BUBBLE;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid : valid/ready pipeline stage, optional two-entry skid buffer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned       WIDTH   = 64,
  parameter logic [WIDTH-1:0] BUBBLE  = '0,
  parameter bit                SKID_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  occ_e             state_q;
  occ_e             state_d;
  logic             in_ready_q;
  logic             in_fire;
  logic             out_fire;
  logic             head_load;
  logic             head_clear;
  logic             skid_load;
  logic [WIDTH-1:0] head_d;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] skid_q;

  // Skid mode keeps in_ready purely registered; reset_n only masks it low.
  assign in_ready  = reset_n && (SKID_EN ? in_ready_q : (!out_valid || out_ready));
  assign out_valid = (state_q != OCC_EMPTY);
  assign out_data  = head_q;
  assign occupancy = state_q;

  always_comb begin
    in_fire    = in_valid && in_ready;
    out_fire   = out_valid && out_ready;
    state_d    = state_q;
    head_load  = 1'b0;
    head_clear = 1'b0;
    skid_load  = 1'b0;
    head_d     = in_data;
    if (flush) begin
      state_d    = OCC_EMPTY;
      head_clear = 1'b1;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (in_fire) begin
            state_d   = OCC_ONE;
            head_load = 1'b1;
          end
        end
        OCC_ONE: begin
          if (in_fire && out_fire) begin
            head_load = 1'b1;
          end else if (in_fire) begin
            // Only reachable with the skid enabled: single-entry mode
            // accepts while holding an entry only when it is also draining.
            if (SKID_EN) begin
              state_d   = OCC_FULL;
              skid_load = 1'b1;
            end
          end else if (out_fire) begin
            state_d    = OCC_EMPTY;
            head_clear = 1'b1;
          end
        end
        OCC_FULL: begin
          if (out_fire) begin
            state_d   = OCC_ONE;
            head_load = 1'b1;
            head_d    = skid_q;
          end
        end
        default: begin
          state_d    = OCC_EMPTY;
          head_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= OCC_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= occ_accepts(state_d);
    end
  end

  pipe_stage_entry #(
    .WIDTH  (WIDTH),
    .BUBBLE (BUBBLE)
  ) u_head (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (head_clear),
    .load_i  (head_load),
    .d_i     (head_d),
    .q_o     (head_q)
  );

  pipe_stage_entry #(
    .WIDTH  (WIDTH),
    .BUBBLE (BUBBLE)
  ) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (1'b0),
    .load_i  (skid_load),
    .d_i     (in_data),
    .q_o     (skid_q)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid : directed vectors plus random handshake scoreboard
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipe_stage_skid;

  localparam logic [15:0] BUB = 16'hF000;

  logic        clk;
  logic        reset_n;
  logic        fl   [2];
  logic        iv   [2];
  logic        ir   [2];
  logic [15:0] din  [2];
  logic        ov   [2];
  logic        rdy  [2];
  logic [15:0] dout [2];
  logic [1:0]  occ  [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Index 0: skid mode, index 1: single-entry mode.
  for (genvar k = 0; k < 2; k++) begin : g_dut
    pipe_stage_skid #(
      .WIDTH   (16),
      .BUBBLE  (16'hF000),
      .SKID_EN (k == 0)
    ) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (fl[k]),
      .in_valid  (iv[k]),
      .in_ready  (ir[k]),
      .in_data   (din[k]),
      .out_valid (ov[k]),
      .out_ready (rdy[k]),
      .out_data  (dout[k]),
      .occupancy (occ[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int k, input logic e_ov, input logic [15:0] e_od,
                            input logic [1:0] e_occ, input logic e_ir);
    check({tag, ".out_valid"}, k, 32'(ov[k]), 32'(e_ov));
    check({tag, ".out_data"},  k, 32'(dout[k]), 32'(e_od));
    check({tag, ".occupancy"}, k, 32'(occ[k]), 32'(e_occ));
    check({tag, ".in_ready"},  k, 32'(ir[k]), 32'(e_ir));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        fl;
    logic        iv;
    logic [15:0] d;
    logic        rdy;
    logic        e_ov;
    logic [15:0] e_od;
    logic [1:0]  e_occ;
    logic        e_ir;
  } vec_t;

  vec_t vt [14];

  // Behavioural reference: an ordered list of at most two live words.
  logic [15:0] mdata [2][2];
  int          mcnt  [2];
  logic        pend  [2];

  initial begin
    // Streaming (V1)
    vt[0]  = '{1'b0, 1'b1, 16'h0001, 1'b1, 1'b1, 16'h0001, 2'd1, 1'b1};
    vt[1]  = '{1'b0, 1'b1, 16'h0002, 1'b1, 1'b1, 16'h0002, 2'd1, 1'b1};
    vt[2]  = '{1'b0, 1'b1, 16'h0003, 1'b1, 1'b1, 16'h0003, 2'd1, 1'b1};
    vt[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, BUB,      2'd0, 1'b1};
    // Backpressure (V2)
    vt[4]  = '{1'b0, 1'b1, 16'h000A, 1'b0, 1'b1, 16'h000A, 2'd1, 1'b1};
    vt[5]  = '{1'b0, 1'b1, 16'h000B, 1'b0, 1'b1, 16'h000A, 2'd2, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 16'h000C, 1'b0, 1'b1, 16'h000A, 2'd2, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 16'h000C, 1'b1, 1'b1, 16'h000B, 2'd1, 1'b1};
    vt[8]  = '{1'b0, 1'b1, 16'h000C, 1'b1, 1'b1, 16'h000C, 2'd1, 1'b1};
    vt[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, BUB,      2'd0, 1'b1};
    // Flush while full with a word on offer (V3)
    vt[10] = '{1'b0, 1'b1, 16'h0011, 1'b0, 1'b1, 16'h0011, 2'd1, 1'b1};
    vt[11] = '{1'b0, 1'b1, 16'h0022, 1'b0, 1'b1, 16'h0011, 2'd2, 1'b0};
    vt[12] = '{1'b1, 1'b1, 16'h0033, 1'b0, 1'b0, BUB,      2'd0, 1'b1};
    vt[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, BUB,      2'd0, 1'b1};

    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      fl[k] = 1'b0; iv[k] = 1'b0; din[k] = 16'h0; rdy[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) check_outs("reset", k, 1'b0, BUB, 2'd0, 1'b0);
    reset_n = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) check("post_reset.in_ready", k, 32'(ir[k]), 32'd1);

    for (int i = 0; i < 14; i++) begin
      fl[0] = vt[i].fl; iv[0] = vt[i].iv; din[0] = vt[i].d; rdy[0] = vt[i].rdy;
      tick();
      check_outs($sformatf("vec%0d", i), 0, vt[i].e_ov, vt[i].e_od, vt[i].e_occ, vt[i].e_ir);
    end

    // Reset mid-stream while full (V4)
    fl[0] = 1'b0; rdy[0] = 1'b0; iv[0] = 1'b1; din[0] = 16'h00A1;
    tick();
    din[0] = 16'h00A2;
    tick();
    check("v4.full", 0, 32'(occ[0]), 32'd2);
    reset_n = 1'b0; din[0] = 16'h00A3;
    tick();
    check_outs("v4.in_reset", 0, 1'b0, BUB, 2'd0, 1'b0);
    check("v4.in_reset.in_ready", 1, 32'(ir[1]), 32'd0);
    reset_n = 1'b1; iv[0] = 1'b0;
    #1;
    check("v4.after.in_ready", 0, 32'(ir[0]), 32'd1);
    iv[0] = 1'b1; din[0] = 16'h5A5A; rdy[0] = 1'b1;
    tick();
    check_outs("v4.first", 0, 1'b1, 16'h5A5A, 2'd1, 1'b1);
    iv[0] = 1'b0;
    tick();
    check_outs("v4.drain", 0, 1'b0, BUB, 2'd0, 1'b1);

    // Single-entry replace-in-one-cycle (V5)
    iv[1] = 1'b1; din[1] = 16'h0101; rdy[1] = 1'b0;
    tick();
    check_outs("v5.hold", 1, 1'b1, 16'h0101, 2'd1, 1'b0);
    din[1] = 16'h0202; rdy[1] = 1'b1;
    #1;
    check("v5.in_ready", 1, 32'(ir[1]), 32'd1);
    tick();
    check_outs("v5.replace", 1, 1'b1, 16'h0202, 2'd1, 1'b1);
    iv[1] = 1'b0;
    tick();
    check_outs("v5.drain", 1, 1'b0, BUB, 2'd0, 1'b1);

    // Random handshake scoreboard on both modes
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0; pend[k] = 1'b0;
      mdata[k][0] = 16'h0; mdata[k][1] = 16'h0;
    end
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!pend[k]) begin
          iv[k]  = ($urandom_range(3) != 0);
          din[k] = 16'($urandom);
        end
        rdy[k] = ($urandom_range(2) != 0);
        fl[k]  = ($urandom_range(40) == 0);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        logic e_ir, e_ov, in_f, out_f;
        logic [15:0] e_od;
        e_ir = (k == 0) ? (mcnt[k] < 2) : ((mcnt[k] == 0) || rdy[k]);
        e_ov = (mcnt[k] > 0);
        e_od = e_ov ? mdata[k][0] : BUB;
        check_outs("rand", k, e_ov, e_od, 2'(mcnt[k]), e_ir);
        in_f  = iv[k] && e_ir;
        out_f = e_ov && rdy[k];
        if (fl[k]) begin
          mcnt[k] = 0;
        end else begin
          if (out_f) begin
            mdata[k][0] = mdata[k][1];
            mcnt[k]--;
          end
          if (in_f) begin
            mdata[k][mcnt[k]] = din[k];
            mcnt[k]++;
          end
        end
        pend[k] = iv[k] && !in_f && !fl[k];
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter WIDTH, default 64: payload width in bits; legal range 1..256.
REQ-002 Parameter BUBBLE, default 0 (WIDTH bits): payload value presented when empty, after reset and after flush, e.g. the NOP instruction word.
REQ-003 Parameter SKID_EN, default 1: 1 = two-entry skid stage with registered in_ready; 0 = single-entry stage with combinational in_ready.
REQ-004 clk  in  1  clock; all state updates on posedge clk.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 flush  in  1  synchronous kill of all held entries.
REQ-007 in_valid  in  1  upstream offers in_data.
REQ-008 in_ready  out  1  stage accepts in_data this cycle.
REQ-009 in_data  in  WIDTH  upstream payload.
REQ-010 out_valid  out  1  out_data holds a live entry.
REQ-011 out_ready  in  1  downstream consumes out_data this cycle.
REQ-012 out_data  out  WIDTH  head-entry payload; equals BUBBLE when out_valid=0.
REQ-013 occupancy  out  2  live entry count, 0..2.

Function
REQ-014 An input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
REQ-015 SKID_EN=1: the block has states EMPTY (occupancy 0), ONE (1) and FULL (2).
REQ-016 SKID_EN=1 transitions:
- EMPTY + input -> ONE.
- ONE + input without output -> FULL; the new data goes to the skid register.
- ONE + output without input -> EMPTY.
- ONE + input + output -> ONE; the head is replaced by in_data.
- FULL + output -> ONE; the skid entry moves to the head.
- All other cases hold state.
REQ-017 SKID_EN=1: in_ready is a register output, equal to (state != FULL); it never depends combinationally on out_ready.
REQ-018 SKID_EN=0: in_ready = !out_valid || out_ready (combinational); occupancy never exceeds 1.
REQ-019 Latency: data accepted at edge N is visible on out_data with out_valid=1 after edge N; the minimum latency is 1 cycle and there is no combinational in_data->out_data path.
REQ-020 Entries leave strictly in acceptance order; no entry is duplicated or dropped except by flush or reset.
REQ-021 While out_valid=1 and out_ready=0, out_data and out_valid hold stable.
REQ-022 Flush has priority over simultaneous input and output transfers: the next state is EMPTY, out_data=BUBBLE, and the in_data offered in the flush cycle is discarded.
REQ-023 An output transfer in the flush cycle is still counted by downstream; the stage makes no attempt to suppress it.
REQ-024 in_valid with in_ready=0 has no effect; upstream holds in_data until the cycle in which it is accepted.
REQ-025 The skid register is loaded only on the ONE->FULL transition; its content is ignored in every other state.

Reset
REQ-026 reset_n=0 at a posedge -> state EMPTY, out_valid=0, out_data=BUBBLE, occupancy=0, skid register=BUBBLE, and in_ready=1 from the following cycle.
REQ-027 Reset has priority over flush and over any transfer; reset asserted while the stage is FULL discards both entries.
REQ-028 During reset, in_ready=0 in both SKID_EN modes.

Structure
REQ-029 The occupancy encoding (EMPTY/ONE/FULL) and the NOP word used as the BUBBLE default for instruction stages shall be defined in the shared pipeline constants package.
REQ-030 The block contains one natural sub-module, pipe_stage_entry: a WIDTH-bit register with load enable and synchronous clear-to-BUBBLE, instantiated as the head and skid registers.
REQ-031 The IF/ID, ID/EX, EX/MEM and MEM/WB latches are built as pipe_stage_skid instances carrying concatenated control and data fields; a legacy stall input maps to out_ready=!stall.

Verification
REQ-032 The bench shall run directed scenarios with WIDTH=16 and BUBBLE=16'hF000, plus a random-handshake scoreboard run in both SKID_EN modes, checking order, that nothing is lost and that REQ-021 holds.
- V1, streaming: in_valid=1 with data 1,2,3 and out_ready=1 -> out_data 1,2,3 on consecutive cycles, each 1 cycle late; occupancy stays at 1.
- V2, backpressure: out_ready=0; push 16'h0A, then 16'h0B -> occupancy=2, in_ready=0, in_data 16'h0C is held off. Raise out_ready -> outputs 0A, 0B, 0C in order.
- V3, flush while FULL with in_valid=1 -> next cycle out_valid=0, out_data=16'hF000, occupancy=0, in_ready=1; the offered word is never output.
- V4, reset mid-stream while FULL -> all outputs at reset values (REQ-026); the first word pushed after reset emerges unchanged.
- V5, SKID_EN=0, out_valid=1, out_ready=1, in_valid=1 in the same cycle -> in_ready=1; the new word replaces the head in one cycle; occupancy stays at 1.
